// File: rtl/fp_multiplier_seq.sv
// fp_multiplier_seq: sequential fp32 multiplier, truncating, radix-configurable
// shift-add mantissa product with valid/ready handshakes on both sides.
module fp_multiplier_seq #(
   parameter int RADIX_BITS = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy
);

   localparam int MUL_CYCLES = 24 / RADIX_BITS;
   localparam int CW         = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
   localparam int SW         = 24 + RADIX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic           sign_q;
   logic [7:0]     exp_a_q, exp_b_q;
   logic [23:0]    mcand_q;
   logic [23:0]    mplier_q;
   // Upper 24 bits of the 48-bit product. Lower bits are shifted out each
   // cycle; only the last one (product bit 23) is kept in guard_q, which is
   // all the unnormalised truncation path needs.
   logic [23:0]    acc_hi_q;
   logic           guard_q;

   logic [SW-1:0]     step_sum;
   logic signed [9:0] e_raw, e_adj;
   logic [22:0]       frac;
   logic [31:0]       result;

   // One radix digit of the multiplier times the multiplicand, added to the
   // running high half before it moves down by RADIX_BITS.
   assign step_sum = SW'(acc_hi_q) + SW'(mcand_q) * SW'(mplier_q[RADIX_BITS-1:0]);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_d = S_MUL;
         end
         S_MUL:  if (cnt_q == CW'(MUL_CYCLES - 1)) state_d = S_NORM;
         S_NORM: state_d = S_DONE;
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Exponent, normalisation and special-case selection for the final word.
   always_comb begin
      e_raw = $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q}) - 10'sd127;
      if (acc_hi_q[23]) begin
         frac  = acc_hi_q[22:0];
         e_adj = e_raw + 10'sd1;
      end else begin
         frac  = {acc_hi_q[21:0], guard_q};
         e_adj = e_raw;
      end
      // Inf beats zero, so Inf*0 is Inf; zero results are always +0.
      if (exp_a_q == 8'hFF || exp_b_q == 8'hFF) result = {sign_q, 8'hFF, 23'h0};
      else if (exp_a_q == 8'h00 || exp_b_q == 8'h00) result = 32'h0;
      else if (e_adj >= 10'sd255) result = {sign_q, 8'hFF, 23'h0};
      else if (e_adj <= 10'sd0) result = 32'h0;
      else result = {sign_q, e_adj[7:0], frac};
   end

   // Operand capture, iterative mantissa product and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         sign_q   <= 1'b0;
         exp_a_q  <= '0;
         exp_b_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_hi_q <= '0;
         guard_q  <= 1'b0;
         out_data <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (in_valid) begin
               sign_q   <= a[31] ^ b[31];
               exp_a_q  <= a[30:23];
               exp_b_q  <= b[30:23];
               mcand_q  <= {1'b1, a[22:0]};
               mplier_q <= {1'b1, b[22:0]};
               acc_hi_q <= '0;
               guard_q  <= 1'b0;
               cnt_q    <= '0;
            end
            S_MUL: begin
               acc_hi_q <= step_sum[SW-1:RADIX_BITS];
               guard_q  <= step_sum[RADIX_BITS-1];
               mplier_q <= mplier_q >> RADIX_BITS;
               cnt_q    <= cnt_q + CW'(1);
            end
            S_NORM:  out_data <= result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_multiplier_seq.sv
// tb_fp_multiplier_seq: directed vectors against a radix-1 and a radix-4 instance
// sharing inputs; checks values, latency, back-pressure, ignored input and reset abort.
module tb_fp_multiplier_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic        in_ready, out_valid, busy;
   logic [31:0] out_data;
   logic        in_ready4, out_valid4, busy4;
   logic [31:0] out_data4;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fp_multiplier_seq #(.RADIX_BITS(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .busy(busy));

   fp_multiplier_seq #(.RADIX_BITS(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
      .a(a), .b(b), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .busy(busy4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present a pair for one cycle; operands are scrambled right after acceptance.
   task automatic accept(input logic [31:0] av, input logic [31:0] bv);
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h1234_5678;
      chk("busy_after_accept", {31'b0, busy}, 32'd1);
      chk("in_ready_after_accept", {31'b0, in_ready}, 32'd0);
   endtask

   // Count edges until each instance raises out_valid (bounded).
   task automatic wait_results(input string tag, input logic [31:0] exp);
      int n = 0, n1 = -1, n4 = -1;
      while (n < 100 && (n1 < 0 || n4 < 0)) begin
         @(posedge clk); #1; n++;
         if (out_valid  && n1 < 0) n1 = n;
         if (out_valid4 && n4 < 0) n4 = n;
      end
      chk({tag, "_lat"},  n1, 32'd25);
      chk({tag, "_lat4"}, n4, 32'd7);
      chk({tag, "_data"},  out_data,  exp);
      chk({tag, "_data4"}, out_data4, exp);
   endtask

   task automatic handoff(input string tag, input logic [31:0] exp);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({tag, "_ov_drop"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
      chk({tag, "_retain"}, out_data, exp);
   endtask

   task automatic run_op(input string tag, input logic [31:0] av,
                         input logic [31:0] bv, input logic [31:0] exp);
      accept(av, bv);
      wait_results(tag, exp);
      handoff(tag, exp);
   endtask

   initial begin
      // Reset values.
      #12;
      chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_out_data",  out_data,           32'h0);
      chk("rst_busy",      {31'b0, busy},      32'd0);
      chk("rst_out_data4", out_data4,          32'h0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("mul2x3",    32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
      run_op("mul1p5sq",  32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);
      run_op("neg_half",  32'hBF80_0000, 32'h3F00_0000, 32'hBF00_0000);
      run_op("zero_pi",   32'h0000_0000, 32'hC049_0FDB, 32'h0000_0000);
      run_op("overflow",  32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000);
      run_op("underflow", 32'h0080_0000, 32'h0080_0000, 32'h0000_0000);
      run_op("inf_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000);
      run_op("neg_inf",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);

      // Back-pressure: hold out_ready low while offering a new pair.
      accept(32'h4000_0000, 32'h4040_0000);
      wait_results("hold", 32'h40C0_0000);
      a = 32'h3F80_0000; b = 32'h3F80_0000; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("hold_ov",   {31'b0, out_valid}, 32'd1);
         chk("hold_data", out_data,           32'h40C0_0000);
         chk("hold_rdy",  {31'b0, in_ready},  32'd0);
      end
      in_valid = 1'b0;
      handoff("hold", 32'h40C0_0000);
      repeat (3) @(posedge clk);
      #1;
      chk("ignored_not_queued", {31'b0, busy}, 32'd0);

      // Async reset in MUL cycle 10, then a clean operation.
      accept(32'h4000_0000, 32'h4040_0000);
      repeat (10) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready",  {31'b0, in_ready},  32'd1);
      chk("abort_busy",      {31'b0, busy},      32'd0);
      chk("abort_out_valid", {31'b0, out_valid4}, 32'd0);
      chk("abort_data",      out_data,           32'h0);
      chk("abort_data4",     out_data4,          32'h0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("after_abort", 32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
